mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
Pipeline MEM stage plus MEM/WB pipeline register. It sits directly downstream of the EX/MEM register and consumes its outputs. It drives a req/ack data-memory port, stalls the upstream pipeline while an access is outstanding, and resolves branch/jump redirects. It also registers write-back data for the WB stage.

Parameters:
TIMEOUT, 16, max cycles in BUSY without dmem_ack before forced completion with error
CNT_W, 5, width of timeout counter; must hold TIMEOUT

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
wb_in  in  2  WB control from EX/MEM, passed to MEM/WB
mem_ctrl_in  in  3  [2]=Branch, [1]=MemRead, [0]=MemWrite
alu_in  in  32  ALU result; memory byte address
rd2_in  in  32  store data
branch_addr_in  in  32  branch target
wn_in  in  5  destination register number
zero_in  in  1  ALU zero flag
jump_in  in  1  jump taken
jump_addr_in  in  32  jump target
dmem_req  out  1  memory request
dmem_we  out  1  write strobe, valid with dmem_req
dmem_addr  out  32  = alu_in
dmem_wdata  out  32  = rd2_in
dmem_rdata  in  32  read data, valid when dmem_ack=1
dmem_ack  in  1  access complete
stall  out  1  freeze PC/IF-ID/ID-EX/EX-MEM (drives their enable low)
redirect  out  1  PC redirect request
redirect_pc  out  32  redirect target
wb_out  out  2  MEM/WB WB control
rdata_out  out  32  MEM/WB loaded data
alu_out  out  32  MEM/WB ALU result
wn_out  out  5  MEM/WB destination register
bus_err  out  1  one-cycle pulse on timeout completion

Behaviour:
- mem_op = MemRead | MemWrite. Both set is an illegal encoding and is treated as a write.
- FSM states: IDLE, BUSY. Reset state is IDLE; timeout counter clears to 0.
- IDLE: if mem_op, go to BUSY next cycle. Otherwise stay in IDLE.
- BUSY: dmem_req=1 and dmem_we=MemWrite. The counter increments each cycle.
- BUSY exit: return to IDLE on dmem_ack or when the counter reaches TIMEOUT-1; the counter clears on exit.
- stall = (IDLE & mem_op) | (BUSY & ~dmem_ack & ~timeout_hit). Stall is combinational, so minimum access latency is 2 cycles (ack in the first BUSY cycle).
- In the completion cycle stall=0. EX/MEM advances and MEM/WB captures on the same edge.
- dmem_addr and dmem_wdata are combinational pass-throughs. dmem_req/dmem_we are 0 outside BUSY and during reset.
- Once dmem_req is asserted it must stay high until completion. The upstream inputs are stable because stall holds EX/MEM.
- MEM/WB register on each edge:
  - reset: all outputs 0.
  - stall=1: bubble. wb_out<=0; other fields hold.
  - otherwise: wb_out<=wb_in, alu_out<=alu_in, wn_out<=wn_in.
  - rdata_out <= dmem_rdata on ack of a read; 0 on timeout; holds for non-reads.
- bus_err: registered. It is 1 for exactly the one cycle after the timeout completion edge, and 0 on reset.
- redirect = (Branch & zero_in) | jump_in, combinational.
- redirect_pc = jump_addr_in if jump_in, else branch_addr_in. Jump has priority when both are set.
- Branch/jump instructions carry no mem_op, so redirect never coincides with stall. If the encoding violates this, redirect is still asserted.
- Reset mid-access: the FSM returns to IDLE, the request drops the same edge, and any late ack is ignored.
- An ack in IDLE is ignored.

Decomposition:
- Shared package pipe_pkg holds:
  - MEM control bit indices (MEM_BRANCH=2, MEM_READ=1, MEM_WRITE=0)
  - WB control width 2 and MEM control width 3
  - FSM state encoding (IDLE=0, BUSY=1)
- One natural sub-module, mem_wb_reg: the MEM/WB register with reset, bubble and capture controls. The FSM, stall and redirect logic stay in mem_stage.

Test Plan:
- Reset: hold reset 2 cycles during BUSY -> all outputs 0, dmem_req=0, FSM IDLE.
- Load with ack: MemRead, alu_in=0x40, dmem_rdata=0xDEADBEEF, ack in 3rd BUSY cycle -> stall high 3 cycles with wb_out bubbles, then rdata_out=0xDEADBEEF, alu_out=0x40.
- Store with zero-wait ack: MemWrite, rd2_in=0x1234, ack in the first BUSY cycle -> dmem_we=1, dmem_wdata=0x1234, stall exactly 1 cycle.
- Timeout: MemRead, TIMEOUT=16, no ack -> stall 16 cycles, then rdata_out=0 and bus_err pulses 1 cycle.
- Redirect: Branch=1, zero=1, branch_addr_in=0x100 -> redirect=1, pc=0x100. With jump_in=1 and jump_addr_in=0x200 as well -> pc=0x200. With zero=0 and no jump -> redirect=0.
- Back-to-back loads and spurious ack in IDLE -> each load stalls independently, and the spurious ack changes nothing.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-field widths, MEM control bit positions,
// MEM-stage FSM encoding and the MEM/WB register payload.
package pipe_pkg;

  localparam int WB_W  = 2;
  localparam int MEM_W = 3;

  localparam int MEM_BRANCH = 2;
  localparam int MEM_READ   = 1;
  localparam int MEM_WRITE  = 0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  // Field order matches the MEM_* bit indices above.
  typedef struct packed {
    logic branch;
    logic mem_read;
    logic mem_write;
  } mem_ctrl_t;

  typedef struct packed {
    logic [WB_W-1:0] wb;
    logic [31:0]     alu;
    logic [4:0]      wn;
  } mem_wb_t;

  function automatic logic is_mem_op(input mem_ctrl_t c);
    return c.mem_read | c.mem_write;
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: captures when not stalled, inserts a WB bubble when stalled.
// Latency 1 cycle; stall only zeroes WB control, the payload holds.
module mem_wb_reg
  import pipe_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            rdata_load,
  input  logic            rdata_clr,
  input  logic [WB_W-1:0] wb_in,
  input  logic [31:0]     alu_in,
  input  logic [4:0]      wn_in,
  input  logic [31:0]     rdata_in,
  output logic [WB_W-1:0] wb_out,
  output logic [31:0]     alu_out,
  output logic [4:0]      wn_out,
  output logic [31:0]     rdata_out
);

  mem_wb_t     q;
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (stall) begin
      q.wb <= '0;
    end else begin
      q.wb  <= wb_in;
      q.alu <= alu_in;
      q.wn  <= wn_in;
    end
  end

  // Load data is written only on the completion edge; a timeout leaves a defined zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (rdata_clr) begin
      rdata_q <= '0;
    end else if (rdata_load) begin
      rdata_q <= rdata_in;
    end
  end

  assign wb_out    = q.wb;
  assign alu_out   = q.alu;
  assign wn_out    = q.wn;
  assign rdata_out = rdata_q;

endmodule

// File: rtl/mem_stage.sv
// MEM stage: req/ack data-memory sequencer with timeout, branch/jump redirect, MEM/WB register.
// Access latency >= 2 cycles; stall holds upstream until ack or timeout completes the access.
module mem_stage
  import pipe_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WB_W-1:0]  wb_in,
  input  logic [MEM_W-1:0] mem_ctrl_in,
  input  logic [31:0]      alu_in,
  input  logic [31:0]      rd2_in,
  input  logic [31:0]      branch_addr_in,
  input  logic [4:0]       wn_in,
  input  logic             zero_in,
  input  logic             jump_in,
  input  logic [31:0]      jump_addr_in,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [31:0]      dmem_addr,
  output logic [31:0]      dmem_wdata,
  input  logic [31:0]      dmem_rdata,
  input  logic             dmem_ack,
  output logic             stall,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic [WB_W-1:0]  wb_out,
  output logic [31:0]      rdata_out,
  output logic [31:0]      alu_out,
  output logic [4:0]       wn_out,
  output logic             bus_err
);

  mem_ctrl_t        ctrl;
  mem_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             mem_op, is_read, busy, timeout_hit, done_tmo;

  assign ctrl    = mem_ctrl_in;
  assign mem_op  = is_mem_op(ctrl);
  // Read+write together is an illegal encoding and behaves as a store.
  assign is_read = ctrl.mem_read & ~ctrl.mem_write;
  assign busy    = (state == BUSY);

  assign timeout_hit = busy && (cnt == CNT_W'(TIMEOUT - 1));
  assign done_tmo    = timeout_hit & ~dmem_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        stall   = mem_op;
        if (mem_op) state_nxt = BUSY;
      end
      BUSY: begin
        dmem_req = 1'b1;
        dmem_we  = ctrl.mem_write;
        stall    = ~dmem_ack & ~timeout_hit;
        if (dmem_ack || timeout_hit) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Reset must silence the memory port and release upstream before the edge lands.
    if (reset) begin
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      stall    = 1'b0;
    end
  end

  assign dmem_addr  = alu_in;
  assign dmem_wdata = rd2_in;

  assign redirect    = (ctrl.branch & zero_in) | jump_in;
  assign redirect_pc = jump_in ? jump_addr_in : branch_addr_in;

  always_ff @(posedge clk) begin
    if (reset) bus_err <= 1'b0;
    else       bus_err <= done_tmo;
  end

  mem_wb_reg u_mem_wb (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .rdata_load (busy & dmem_ack & is_read),
    .rdata_clr  (done_tmo),
    .wb_in      (wb_in),
    .alu_in     (alu_in),
    .wn_in      (wn_in),
    .rdata_in   (dmem_rdata),
    .wb_out     (wb_out),
    .alu_out    (alu_out),
    .wn_out     (wn_out),
    .rdata_out  (rdata_out)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Randomized and directed bench for mem_stage against a per-instruction reference model.
module tb_mem_stage;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  wb_in;
  logic [2:0]  mem_ctrl_in;
  logic [31:0] alu_in, rd2_in, branch_addr_in, jump_addr_in, dmem_rdata;
  logic [4:0]  wn_in;
  logic        zero_in, jump_in, dmem_ack;
  logic        dmem_req, dmem_we, stall, redirect, bus_err;
  logic [31:0] dmem_addr, dmem_wdata, redirect_pc, rdata_out, alu_out;
  logic [1:0]  wb_out;
  logic [4:0]  wn_out;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_rdata;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(TMO), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .wb_in(wb_in), .mem_ctrl_in(mem_ctrl_in),
    .alu_in(alu_in), .rd2_in(rd2_in), .branch_addr_in(branch_addr_in),
    .wn_in(wn_in), .zero_in(zero_in), .jump_in(jump_in), .jump_addr_in(jump_addr_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .wb_out(wb_out), .rdata_out(rdata_out), .alu_out(alu_out),
    .wn_out(wn_out), .bus_err(bus_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_nop();
    wb_in = 0; mem_ctrl_in = 0; alu_in = 0; rd2_in = 0; branch_addr_in = 0;
    wn_in = 0; zero_in = 0; jump_in = 0; jump_addr_in = 0; dmem_ack = 0; dmem_rdata = 0;
  endtask

  task automatic check_regs_zero(input string tag);
    check({tag, ".wb"}, 32'(wb_out), 0);
    check({tag, ".alu"}, alu_out, 0);
    check({tag, ".wn"}, 32'(wn_out), 0);
    check({tag, ".rdata"}, rdata_out, 0);
    check({tag, ".bus_err"}, 32'(bus_err), 0);
    check({tag, ".req"}, 32'(dmem_req), 0);
  endtask

  // One instruction held in EX/MEM until the stage releases it.
  // ack_at: BUSY cycle (1-based) that carries the ack, 0 = never acked.
  task automatic run_instr(input logic [1:0] wb, input logic [2:0] ctrl,
                           input logic [31:0] alu, input logic [31:0] rd2,
                           input logic [31:0] baddr, input logic [31:0] jaddr,
                           input logic [4:0] wn, input logic zero, input logic jmp,
                           input int ack_at, input logic [31:0] rdat, input logic spur);
    bit mem, wr, rd_op, tmo, exp_redir;
    int exp_stall, nst;
    logic [31:0] exp_pc;
    mem   = ctrl[1] | ctrl[0];
    wr    = ctrl[0];
    rd_op = ctrl[1] & ~ctrl[0];
    tmo   = mem && (ack_at == 0);
    exp_stall = !mem ? 0 : (tmo ? TMO : ack_at);
    exp_redir = (ctrl[2] && zero) || jmp;
    if (jmp) exp_pc = jaddr; else exp_pc = baddr;

    wb_in = wb; mem_ctrl_in = ctrl; alu_in = alu; rd2_in = rd2; branch_addr_in = baddr;
    jump_addr_in = jaddr; wn_in = wn; zero_in = zero; jump_in = jmp;
    nst = 0;
    for (int cyc = 0; ; cyc++) begin
      dmem_ack = (spur && cyc == 0) || (mem && ack_at != 0 && cyc == ack_at);
      dmem_rdata = (mem && cyc == ack_at) ? rdat : $urandom;
      @(negedge clk);
      if (cyc == 0) begin
        check("redirect", 32'(redirect), 32'(exp_redir));
        if (exp_redir) check("redirect_pc", redirect_pc, exp_pc);
        check("dmem_addr", dmem_addr, alu);
        check("dmem_wdata", dmem_wdata, rd2);
        check("req_idle", 32'(dmem_req), 0);
      end else begin
        check("req_busy", 32'(dmem_req), 1);
        check("we_busy", 32'(dmem_we), 32'(wr));
        check("wb_bubble", 32'(wb_out), 0);
      end
      if (!stall) break;
      nst++;
      if (cyc > 40) begin
        check("stall_bound", 32'(cyc), 40);
        break;
      end
      tick();
    end
    tick();
    dmem_ack = 0;
    if (mem && rd_op && !tmo) exp_rdata = rdat;
    if (tmo) exp_rdata = 0;
    check("stall_cycles", 32'(nst), 32'(exp_stall));
    check("wb_out", 32'(wb_out), 32'(wb));
    check("alu_out", alu_out, alu);
    check("wn_out", 32'(wn_out), 32'(wn));
    check("rdata_out", rdata_out, exp_rdata);
    check("bus_err", 32'(bus_err), 32'(tmo));
  endtask

  initial begin
    drive_nop();
    exp_rdata = 0;
    reset = 1;
    tick(); tick();
    @(negedge clk);
    check_regs_zero("por");
    check("por.stall", 32'(stall), 0);
    tick();
    reset = 0;

    // Reset in the middle of an access, then a late ack that must be ignored.
    wb_in = 2'b11; mem_ctrl_in = 3'b010; alu_in = 32'h80; wn_in = 5'd7;
    tick(); tick(); tick();
    @(negedge clk);
    check("mid.req", 32'(dmem_req), 1);
    tick();
    reset = 1;
    @(negedge clk);
    check("rst.req", 32'(dmem_req), 0);
    check("rst.stall", 32'(stall), 0);
    tick(); tick();
    check_regs_zero("rst");
    drive_nop();
    reset = 0;
    dmem_ack = 1; dmem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    check("late_ack.stall", 32'(stall), 0);
    check("late_ack.req", 32'(dmem_req), 0);
    tick();
    dmem_ack = 0;
    check("late_ack.rdata", rdata_out, 0);

    // Directed scenarios
    run_instr(2'b11, 3'b010, 32'h40, 0, 0, 0, 5'd3, 0, 0, 3, 32'hDEADBEEF, 0);
    run_instr(2'b00, 3'b001, 32'h44, 32'h1234, 0, 0, 5'd0, 0, 0, 1, 0, 0);
    run_instr(2'b01, 3'b010, 32'h48, 0, 0, 0, 5'd9, 0, 0, 0, 0, 0);
    run_instr(2'b00, 3'b100, 0, 0, 32'h100, 0, 5'd0, 1, 0, 0, 0, 0);
    run_instr(2'b00, 3'b100, 0, 0, 32'h100, 32'h200, 5'd0, 1, 1, 0, 0, 0);
    run_instr(2'b00, 3'b100, 0, 0, 32'h100, 32'h200, 5'd0, 0, 0, 0, 0, 0);
    run_instr(2'b10, 3'b010, 32'h50, 0, 0, 0, 5'd4, 0, 0, 2, 32'hCAFEF00D, 0);
    run_instr(2'b10, 3'b010, 32'h54, 0, 0, 0, 5'd5, 0, 0, 1, 32'h0BADCAFE, 0);
    run_instr(2'b11, 3'b000, 32'h58, 0, 0, 0, 5'd6, 0, 0, 0, 0, 1);
    run_instr(2'b11, 3'b011, 32'h5C, 32'h77, 0, 0, 5'd8, 0, 0, 2, 32'h11111111, 0);

    // Randomized instruction mix
    for (int i = 0; i < 60; i++) begin
      int kind, ack;
      logic [2:0] c;
      kind = $urandom_range(0, 4);
      case (kind)
        0: c = 3'b000;
        1: c = 3'b010;
        2: c = 3'b001;
        3: c = 3'b011;
        default: c = 3'b100;
      endcase
      ack = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
      run_instr(2'($urandom), c, $urandom, $urandom, $urandom, $urandom, 5'($urandom),
                1'($urandom), (kind == 4) ? 1'($urandom) : 1'b0,
                ack, $urandom, (c[1:0] == 2'b00) ? 1'($urandom) : 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
